// File: rtl/ram_b_read_arbiter_if.sv
// RAM port B read-arbiter bus bundle.
//
// Groups both requester handshakes, the shared return data, the RAM port B
// address/data pair and the busy flag.
//   master : requester and RAM side (drives req/addr and ram_q_b)
//   slave  : arbiter side (drives grants, rvalids, rdata, ram_addr_b, busy)
interface ram_b_read_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 24
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_q_b;
    logic              busy;

    modport master (
        output req0, addr0, req1, addr1, ram_q_b,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata, ram_addr_b, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1, ram_q_b,
        output gnt0, rvalid0, gnt1, rvalid1, rdata, ram_addr_b, busy
    );
endinterface

// File: rtl/ram_b_read_arbiter.sv
// Arbiter sharing the read-only port B of the data RAM between two requesters.
//
// Requester 0 (display fetch) has priority; requester 1 (debug/host) wins once
// after STARVE_LIMIT consecutive denied cycles. One grant per cycle, the RAM
// address is driven combinationally, and a {valid, owner} tag pipeline of
// READ_LATENCY stages steers the returning data to its owner.
//
// Ports:
//   CLK  : clock, shared with RAM port B
//   RST  : asynchronous active-low reset
//   bus  : slave side of ram_b_read_arbiter_if (requests, grants, return
//          data, RAM port B address/data, busy)
module ram_b_read_arbiter #(
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                 CLK,
    input logic                 RST,
    ram_b_read_arbiter_if.slave bus
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    logic [CntW-1:0]         starve_cnt;
    logic                    starve;
    logic                    gnt0;
    logic                    gnt1;
    logic                    gnt_any;
    logic [ADDR_W-1:0]       addr_mux;
    logic [ADDR_W-1:0]       held_addr;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [READ_LATENCY-1:0] tag_owner;

    // Grants are qualified by RST so they drop the instant reset asserts,
    // without waiting for a clock edge.
    always_comb begin
        starve   = (starve_cnt >= CntW'(STARVE_LIMIT));
        gnt1     = RST & bus.req1 & (~bus.req0 | starve);
        gnt0     = RST & bus.req0 & ~gnt1;
        gnt_any  = gnt0 | gnt1;
        addr_mux = held_addr;
        if (gnt0) begin
            addr_mux = bus.addr0;
        end else if (gnt1) begin
            addr_mux = bus.addr1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            starve_cnt <= '0;
            held_addr  <= '0;
            tag_valid  <= '0;
            tag_owner  <= '0;
        end else begin
            if (gnt1 || !bus.req1) begin
                starve_cnt <= '0;
            end else if (!starve) begin
                starve_cnt <= starve_cnt + CntW'(1);
            end

            // Keep the RAM address stable when idle to avoid needless toggling.
            if (gnt_any) begin
                held_addr <= addr_mux;
            end

            tag_valid[0] <= gnt_any;
            tag_owner[0] <= gnt1;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    assign bus.gnt0       = gnt0;
    assign bus.gnt1       = gnt1;
    assign bus.ram_addr_b = addr_mux;
    assign bus.rvalid0    = tag_valid[READ_LATENCY-1] & ~tag_owner[READ_LATENCY-1];
    assign bus.rvalid1    = tag_valid[READ_LATENCY-1] & tag_owner[READ_LATENCY-1];
    assign bus.rdata      = (bus.rvalid0 | bus.rvalid1) ? bus.ram_q_b : '0;
    assign bus.busy       = |tag_valid;

endmodule

// File: tb/tb_ram_b_read_arbiter.sv
// Self-checking bench for ram_b_read_arbiter with a registered-address,
// registered-output RAM model and a cycle-level reference model.
module tb_ram_b_read_arbiter;

    localparam int L     = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_b_read_arbiter_if #(.ADDR_W(18), .DATA_W(24)) bus ();

    ram_b_read_arbiter #(
        .ADDR_W      (18),
        .DATA_W      (24),
        .READ_LATENCY(L),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // RAM port B: registered address, registered output.
    logic [23:0] mem [0:262143];
    logic [17:0] ram_a_r = '0;
    logic [23:0] ram_q   = '0;
    always @(posedge clk) begin
        ram_a_r <= bus.ram_addr_b;
        ram_q   <= mem[ram_a_r];
    end
    assign bus.ram_q_b = ram_q;

    // Reference model state: grant history ring, starvation count, last address.
    int          sc;
    logic [17:0] last_addr;
    logic        hv [8];
    logic        ho [8];
    logic [17:0] ha [8];
    int          cyc;

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_gnt0, s_gnt1, s_rv0, s_rv1, s_busy;
    logic [23:0] s_rdata;
    logic [17:0] s_addr;
    logic        e_gnt0, e_gnt1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        sc        = 0;
        last_addr = '0;
        for (int i = 0; i < 8; i++) begin
            hv[i] = 1'b0;
            ho[i] = 1'b0;
            ha[i] = '0;
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, compare against model, advance.
    task automatic step(input logic r0, input logic [17:0] a0,
                        input logic r1, input logic [17:0] a1);
        logic        starve, eg0, eg1, erv0, erv1, ebusy;
        logic [17:0] ea;
        logic [23:0] ed;
        int          ri;
        @(posedge clk);
        #1;
        bus.req0  = r0;
        bus.addr0 = a0;
        bus.req1  = r1;
        bus.addr1 = a1;
        @(negedge clk);
        starve = (sc >= LIMIT);
        eg1    = r1 && (!r0 || starve);
        eg0    = r0 && !eg1;
        ea     = eg0 ? a0 : (eg1 ? a1 : last_addr);
        ri     = (cyc - L) & 7;
        erv0   = hv[ri] && !ho[ri];
        erv1   = hv[ri] && ho[ri];
        ed     = (erv0 || erv1) ? mem[ha[ri]] : 24'h0;
        ebusy  = 1'b0;
        for (int k = 1; k <= L; k++) ebusy = ebusy | hv[(cyc - k) & 7];

        s_gnt0  = bus.gnt0;
        s_gnt1  = bus.gnt1;
        s_rv0   = bus.rvalid0;
        s_rv1   = bus.rvalid1;
        s_busy  = bus.busy;
        s_rdata = bus.rdata;
        s_addr  = bus.ram_addr_b;
        chk("gnt0", 32'(s_gnt0), 32'(eg0));
        chk("gnt1", 32'(s_gnt1), 32'(eg1));
        chk("ram_addr_b", 32'(s_addr), 32'(ea));
        chk("rvalid0", 32'(s_rv0), 32'(erv0));
        chk("rvalid1", 32'(s_rv1), 32'(erv1));
        chk("rdata", 32'(s_rdata), 32'(ed));
        chk("busy", 32'(s_busy), 32'(ebusy));

        hv[cyc & 7] = eg0 | eg1;
        ho[cyc & 7] = eg1;
        ha[cyc & 7] = ea;
        if (eg0 || eg1) last_addr = ea;
        if (eg1 || !r1) sc = 0;
        else if (sc < LIMIT) sc++;
        e_gnt0 = eg0;
        e_gnt1 = eg1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 18'h0, 1'b0, 18'h0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_gnt0"}, 32'(bus.gnt0), 32'h0);
        chk({nm, "_gnt1"}, 32'(bus.gnt1), 32'h0);
        chk({nm, "_rvalid0"}, 32'(bus.rvalid0), 32'h0);
        chk({nm, "_rvalid1"}, 32'(bus.rvalid1), 32'h0);
        chk({nm, "_busy"}, 32'(bus.busy), 32'h0);
        chk({nm, "_rdata"}, 32'(bus.rdata), 32'h0);
        chk({nm, "_addr"}, 32'(bus.ram_addr_b), 32'h0);
    endtask

    logic        cap_rv0 [8];
    logic        cap_rv1 [8];
    logic        cap_busy[8];
    logic [23:0] cap_data[8];

    initial begin : main
        logic        r0, r1;
        logic [17:0] a0, a1;

        for (int i = 0; i < 262144; i++) mem[i] = 24'((i * 7919 + 32'h1234) & 32'hFFFFFF);
        cyc = 0;
        model_reset();
        bus.req0  = 1'b0;
        bus.addr0 = '0;
        bus.req1  = 1'b0;
        bus.addr1 = '0;
        #1;
        chk_all_zero("por");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(3);

        // Single read of a preloaded word.
        mem[18'h10] = 24'hABCDEF;
        step(1'b1, 18'h10, 1'b0, 18'h0);
        chk("single_gnt0", 32'(s_gnt0), 32'h1);
        idle(1);
        chk("single_early", 32'(s_rv0), 32'h0);
        idle(1);
        chk("single_rv0", 32'(s_rv0), 32'h1);
        chk("single_rdata", 32'(s_rdata), 32'hABCDEF);
        chk("single_rv1", 32'(s_rv1), 32'h0);
        idle(3);

        // Both requesting: requester 1 wins only on the fifth cycle.
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 18'(i), 1'b1, 18'h200);
            chk("simul_gnt1", 32'(s_gnt1), (i == 4) ? 32'h1 : 32'h0);
            chk("simul_gnt0", 32'(s_gnt0), (i == 4) ? 32'h0 : 32'h1);
        end
        idle(4);

        // Back-to-back streaming.
        for (int k = 0; k < 4; k++) mem[k] = 24'(k + 'h100);
        for (int c = 0; c < 8; c++) begin
            if (c < 4) step(1'b1, 18'(c), 1'b0, 18'h0);
            else idle(1);
            cap_rv0[c]  = s_rv0;
            cap_busy[c] = s_busy;
            cap_data[c] = s_rdata;
        end
        for (int c = 0; c < 8; c++) begin
            chk("stream_rv0", 32'(cap_rv0[c]), (c >= 2 && c <= 5) ? 32'h1 : 32'h0);
            chk("stream_busy", 32'(cap_busy[c]), (c >= 1 && c <= 5) ? 32'h1 : 32'h0);
            if (c >= 2 && c <= 5) chk("stream_rdata", 32'(cap_data[c]), 32'('h100 + c - 2));
        end
        idle(2);

        // Interleaved ownership.
        mem[18'h3FFFF] = 24'h5A5A5A;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) step(1'b0, 18'h0, 1'b1, 18'h3FFFF);
            else if (c == 1) step(1'b1, 18'h0, 1'b0, 18'h0);
            else idle(1);
            cap_rv0[c]  = s_rv0;
            cap_rv1[c]  = s_rv1;
            cap_data[c] = s_rdata;
        end
        chk("inter_rv1", 32'(cap_rv1[2]), 32'h1);
        chk("inter_rv0_c2", 32'(cap_rv0[2]), 32'h0);
        chk("inter_data1", 32'(cap_data[2]), 32'h5A5A5A);
        chk("inter_rv0", 32'(cap_rv0[3]), 32'h1);
        chk("inter_rv1_c3", 32'(cap_rv1[3]), 32'h0);
        chk("inter_data0", 32'(cap_data[3]), 32'h100);
        idle(2);

        // Starvation counter cleared by a gap in req1.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 18'(i), (i != 2 && i != 8), 18'h155);
            chk("starve_clr_gnt1", 32'(s_gnt1), (i == 7) ? 32'h1 : 32'h0);
        end
        idle(3);

        // Reset while a grant is one cycle into the pipeline.
        step(1'b1, 18'h77, 1'b0, 18'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        bus.req0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            idle(1);
            chk("rst_no_rv0", 32'(s_rv0), 32'h0);
            chk("rst_addr", 32'(s_addr), 32'h0);
        end

        // Randomized traffic with request holding until granted.
        r0 = 1'b0; r1 = 1'b0; a0 = '0; a1 = '0;
        for (int c = 0; c < 3000; c++) begin
            step(r0, a0, r1, a1);
            if (e_gnt0 || !r0) begin
                r0 = (($urandom % 8) < ((c / 500) % 2 == 0 ? 7 : 3));
                a0 = 18'($urandom);
            end
            if (e_gnt1 || !r1) begin
                r1 = (($urandom % 3) == 0);
                a1 = 18'($urandom);
            end
            chk("rv_exclusive", 32'(s_rv0 & s_rv1), 32'h0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
